// File: rtl/hamming_secded_pipe.sv
// SECDED (extended Hamming) protected two-stage pipeline: encode into a one-entry buffer, decode/correct into an output register.
// Optional macro HAMMING_SCRUB_EN adds in-place scrubbing of the stalled buffer word and the scrub_o pulse.
module hamming_secded_pipe #(
    parameter  int DATA_W   = 26,
    parameter  int CNT_W    = 8,
    localparam int N_CHECKB = (DATA_W <= 4)  ? 3 :
                              (DATA_W <= 11) ? 4 :
                              (DATA_W <= 26) ? 5 :
                              (DATA_W <= 57) ? 6 : 7,
    localparam int CW_W     = DATA_W + N_CHECKB + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CW_W-1:0]   inj_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sec_o,
    output logic              ded_o,
    output logic [CNT_W-1:0]  sec_cnt_o,
    output logic              ded_sticky_o,
`ifdef HAMMING_SCRUB_EN
    output logic              scrub_o,
`endif
    input  logic              clear_i
);

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        int j;
        cw = '0;
        j  = 0;
        for (int p = 1; p < CW_W; p++) begin
            if (!is_pow2(p)) begin
                cw[p] = d[j];
                j++;
            end
        end
        // Each check bit makes its own parity group even, so a clean word has zero syndrome.
        for (int k = 0; k < N_CHECKB; k++) begin
            for (int p = 1; p < CW_W; p++) begin
                if (!is_pow2(p) && p[k]) cw[1 << k] = cw[1 << k] ^ cw[p];
            end
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic logic [N_CHECKB-1:0] syndrome(input logic [CW_W-1:0] cw);
        logic [N_CHECKB-1:0] s;
        s = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (cw[p]) s = s ^ N_CHECKB'(p);
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p < CW_W; p++) begin
            if (!is_pow2(p)) begin
                d[j] = cw[p];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [CW_W-1:0]     cw_p1;
    logic                vld_p1;
    logic [DATA_W-1:0]   data_p2;
    logic                sec_p2, ded_p2, vld_p2;
    logic [CNT_W-1:0]    sec_cnt;
    logic                ded_sticky;

    logic                adv, accept, load;
    logic [N_CHECKB-1:0] syn;
    logic                par;
    logic [CW_W-1:0]     cw_fix;
    logic                dec_sec, dec_ded;
    logic [DATA_W-1:0]   dec_data;

    assign adv     = !vld_p2 || ready_i;
    assign ready_o = !vld_p1 || adv;
    assign accept  = valid_i && ready_o;
    assign load    = adv && vld_p1;

    always_comb begin
        syn     = syndrome(cw_p1);
        par     = ^cw_p1;
        cw_fix  = cw_p1;
        dec_sec = 1'b0;
        dec_ded = 1'b0;
        if (par) begin
            // A syndrome pointing past the codeword can only come from a multi-bit error.
            if (32'(syn) >= CW_W) begin
                dec_ded = 1'b1;
            end else begin
                cw_fix  = cw_p1 ^ (CW_W'(1) << syn);
                dec_sec = 1'b1;
            end
        end else if (syn != '0) begin
            dec_ded = 1'b1;
        end
        dec_data = extract(cw_fix);
    end

    // ---- S1: protected buffer ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            cw_p1  <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            cw_p1  <= encode(data_i) ^ inj_i;
        end else if (adv) begin
            vld_p1 <= 1'b0;
`ifdef HAMMING_SCRUB_EN
        end else if (vld_p1 && dec_sec) begin
            cw_p1  <= cw_fix;
`endif
        end
    end

`ifdef HAMMING_SCRUB_EN
    assign scrub_o = vld_p1 && !adv && dec_sec;
`endif

    // ---- S2: corrected output register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            sec_p2  <= 1'b0;
            ded_p2  <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= dec_data;
                sec_p2  <= dec_sec;
                ded_p2  <= dec_ded;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sec_cnt    <= '0;
            ded_sticky <= 1'b0;
        end else if (clear_i) begin
            sec_cnt    <= (load && dec_sec) ? CNT_W'(1) : '0;
            ded_sticky <= load && dec_ded;
        end else begin
            if (load && dec_sec) sec_cnt <= sat_inc(sec_cnt);
            if (load && dec_ded) ded_sticky <= 1'b1;
        end
    end

    assign valid_o      = vld_p2;
    assign data_o       = data_p2;
    assign sec_o        = sec_p2;
    assign ded_o        = ded_p2;
    assign sec_cnt_o    = sec_cnt;
    assign ded_sticky_o = ded_sticky;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Self-checking bench for hamming_secded_pipe: directed steps plus random traffic against an error-class reference model.
module tb_hamming_secded_pipe;

    localparam int DW   = 26;
    localparam int CW   = 32;
    localparam int CNTW = 2;
    localparam int CMAX = 3;
`ifdef HAMMING_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_i, valid_i, ready_o, valid_o, ready_i;
    logic            sec_o, ded_o, ded_sticky_o, clear_i;
    logic [DW-1:0]   data_i, data_o;
    logic [CW-1:0]   inj_i;
    logic [CNTW-1:0] sec_cnt_o;
`ifdef HAMMING_SCRUB_EN
    logic            scrub_o;
`endif

    hamming_secded_pipe #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .inj_i(inj_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .sec_o(sec_o), .ded_o(ded_o), .sec_cnt_o(sec_cnt_o),
        .ded_sticky_o(ded_sticky_o),
`ifdef HAMMING_SCRUB_EN
        .scrub_o(scrub_o),
`endif
        .clear_i(clear_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          sec;
        logic          ded;
        int            cnt;
        logic          stk;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   dpos[DW];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, mcnt = 0, stall_left = 0;
    bit   mstk = 0, rand_bp = 0, force_clean = 0, clr_with_load = 0, last_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] inj_data(input logic [CW-1:0] inj);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = inj[dpos[i]];
        return d;
    endfunction

    // Code is linear: the outcome depends only on the weight of the injected mask.
    task automatic push_exp(input logic [DW-1:0] d, input logic [CW-1:0] inj);
        exp_t e;
        int   w;
        w     = $countones(inj);
        e.d   = (w == 2) ? (d ^ inj_data(inj)) : d;
        e.sec = (w == 1) && !force_clean;
        e.ded = (w == 2);
        if (e.sec) mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
        if (e.ded) mstk = 1'b1;
        e.cnt = mcnt;
        e.stk = mstk;
        e.acc = cyc;
        q.push_back(e);
    endtask

    function automatic logic [CW-1:0] rand_inj(input int maxw);
        logic [CW-1:0] inj;
        int w;
        w = $urandom_range(0, maxw);
        if (SCRUB && w == 1) w = 2;
        inj = '0;
        while ($countones(inj) < w) inj[$urandom_range(0, CW-1)] = 1'b1;
        return inj;
    endfunction

    task automatic tick();
        bit acc, hs;
        if (stall_left > 0) begin
            ready_i = 1'b0;
            stall_left--;
        end else begin
            ready_i = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        @(negedge clk);
        chk("ready_o", ready_o, (q.size() < 2) || ready_i);
        chk("valid_o", valid_o, (q.size() > 0) && (q[0].acc < cyc));
        if (valid_o && q.size() > 0) begin
            chk("data_o", data_o, q[0].d);
            chk("sec_o", sec_o, q[0].sec);
            chk("ded_o", ded_o, q[0].ded);
            chk("sec_cnt_o", sec_cnt_o, q[0].cnt);
            chk("ded_sticky_o", ded_sticky_o, q[0].stk);
        end
        acc = valid_i && ready_o;
        hs  = valid_o && ready_i;
        @(posedge clk);
        cyc++;
        if (hs && q.size() > 0) void'(q.pop_front());
        if (acc) push_exp(data_i, inj_i);
        if (clear_i) begin
            if (clr_with_load && q.size() > 0) begin
                q[0].cnt = q[0].sec ? 1 : 0;
                q[0].stk = q[0].ded;
                mcnt     = q[0].cnt;
                mstk     = q[0].stk;
            end else begin
                mcnt = 0;
                mstk = 1'b0;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] inj);
        valid_i  = 1'b1;
        data_i   = d;
        inj_i    = inj;
        last_acc = 1'b0;
        for (int k = 0; k < 60 && !last_acc; k++) tick();
        chk("send_accepted", last_acc, 1'b1);
        valid_i = 1'b0;
        inj_i   = '0;
    endtask

    task automatic drain();
        valid_i = 1'b0;
        for (int k = 0; k < 100 && q.size() > 0; k++) tick();
        chk("drain_done", q.size(), 0);
    endtask

    task automatic clear_cycle(input bit with_load);
        clear_i       = 1'b1;
        clr_with_load = with_load;
        tick();
        clear_i       = 1'b0;
        clr_with_load = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_data"}, data_o, '0);
        chk({tag, "_sec"}, sec_o, 1'b0);
        chk({tag, "_ded"}, ded_o, 1'b0);
        chk({tag, "_cnt"}, sec_cnt_o, '0);
        chk({tag, "_sticky"}, ded_sticky_o, 1'b0);
        chk({tag, "_ready"}, ready_o, 1'b1);
    endtask

    initial begin
        int idx;
        idx = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                dpos[idx] = p;
                idx++;
            end
        end

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0;
        data_i = '0; inj_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_i = 1'b0;

        // Clean path
        send(26'h2AA_AAAA, '0);
        drain();
        chk("clean_cnt", sec_cnt_o, 0);

        // Single data error at data_i[1]
        send(26'h000_0003, 32'(1) << 5);
        drain();
        chk("sec_data_cnt", sec_cnt_o, 1);

        // Overall parity bit only
        send(DW'($urandom), 32'h1);
        drain();
        chk("sec_par_cnt", sec_cnt_o, 2);

        // Double error, sticky until cleared
        send(DW'($urandom), (32'(1) << 3) | (32'(1) << 9));
        drain();
        repeat (3) tick();
        chk("ded_sticky_hold", ded_sticky_o, 1'b1);

        send(DW'($urandom), '0);
        clear_cycle(1'b1);
        drain();
        chk("clear_clean_sticky", ded_sticky_o, 1'b0);
        chk("clear_clean_cnt", sec_cnt_o, 0);

        send(DW'($urandom), 32'(1) << 12);
        clear_cycle(1'b1);
        drain();
        chk("clear_sec_cnt", sec_cnt_o, 1);

        send(DW'($urandom), (32'(1) << 0) | (32'(1) << 20));
        drain();
        chk("ded2_sticky", ded_sticky_o, 1'b1);
        clear_cycle(1'b0);
        chk("clear_only_cnt", sec_cnt_o, 0);
        chk("clear_only_sticky", ded_sticky_o, 1'b0);

        // Saturation with four single-error words back to back
        for (int i = 0; i < 4; i++) send(DW'($urandom), 32'(1) << $urandom_range(0, CW-1));
        drain();
        chk("sat_cnt", sec_cnt_o, CMAX);

        // Backpressure: 5 stalled cycles, 3 words offered
        stall_left = 5;
        send(DW'($urandom), rand_inj(0));
        send(DW'($urandom), rand_inj(2));
        chk("bp_ready_low", ready_o, 1'b0);
        send(DW'($urandom), rand_inj(2));
        drain();

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) send(DW'($urandom), rand_inj(2));
        drain();
        rand_bp = 1'b0;

`ifdef HAMMING_SCRUB_EN
        clear_cycle(1'b0);
        stall_left = 1000;
        send(DW'($urandom), '0);
        force_clean = 1'b1;
        send(DW'($urandom), 32'(1) << 7);
        force_clean = 1'b0;
        chk("scrub_pulse", scrub_o, 1'b1);
        tick();
        chk("scrub_once", scrub_o, 1'b0);
        tick();
        chk("scrub_quiet", scrub_o, 1'b0);
        stall_left = 0;
        drain();
        chk("scrub_cnt", sec_cnt_o, 0);
`endif

        // Reset with both stages full
        stall_left = 1000;
        send(DW'($urandom), 32'(1) << 4);
        send(DW'($urandom), '0);
        chk("rst_full_valid", valid_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        rst_i = 1'b0;
        q.delete();
        mcnt = 0;
        mstk = 1'b0;
        stall_left = 0;
        repeat (3) tick();
        chk("post_rst_cnt", sec_cnt_o, 0);

        send(26'h155_5555, 32'(1) << 30);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
